tt_um_initial_project: RTL and testbench

TT_UM_INITIAL_PROJECT -- requirements
Module: tt_um_initial_project

---
 rtl/tt_um_initial_project.sv | 59 +++++
 tb/tb_tt_um_initial_project.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_initial_project.sv
// tt_um_initial_project: command-driven up/down step counter with compare, sticky match/wrap flags and a PWM output
module tt_um_initial_project (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD, OP_SETCMP, OP_SETSTEP, OP_RUNUP, OP_RUNDN, OP_STOP, OP_CLEAR
  } op_e;
  logic [7:0] r_count, r_cmp, r_step;
  logic       r_running, r_dir, r_match, r_wrap;
  op_e        w_op;
  logic       w_cmd, w_tick, w_carry, w_pwm, w_unused;
  logic [8:0] w_sum;
  logic [7:0] w_next;
  assign w_op     = op_e'(uio_in[2:0]);
  assign w_cmd    = ena & uio_in[3];
  assign w_tick   = ena & ~uio_in[3] & r_running;
  assign w_sum    = {1'b0, r_count} + {1'b0, r_step};
  assign w_next   = r_dir ? r_count - r_step : w_sum[7:0];
  assign w_carry  = r_dir ? r_count < r_step : w_sum[8];
  assign w_pwm    = r_count < r_cmp;
  assign w_unused = &{1'b0, uio_in[7:4]};
  assign uo_out   = r_count;
  assign uio_out  = {r_wrap, r_match, r_running, w_pwm, 4'b0000};
  assign uio_oe   = 8'hF0;
  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count   <= 8'h00;
      r_cmp     <= 8'h80;
      r_step    <= 8'h01;
      r_running <= 1'b0;
      r_dir     <= 1'b0;
      r_match   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_cmd) begin
      case (w_op)
        OP_NOP:     ;
        OP_LOAD:    r_count <= ui_in;
        OP_SETCMP:  r_cmp <= ui_in;
        OP_SETSTEP: r_step <= ui_in;
        OP_RUNUP:   begin r_running <= 1'b1; r_dir <= 1'b0; end
        OP_RUNDN:   begin r_running <= 1'b1; r_dir <= 1'b1; end
        OP_STOP:    r_running <= 1'b0;
        OP_CLEAR:   begin r_count <= 8'h00; r_match <= 1'b0; r_wrap <= 1'b0; end
      endcase
    end else if (w_tick) begin
      r_count <= w_next;
      if (w_carry) r_wrap <= 1'b1;
      if (w_next == r_cmp) r_match <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tt_um_initial_project.sv
// tb_tt_um_initial_project: directed and randomized checks against a behavioural counter model
module tb_tt_um_initial_project;
  logic       clk = 1'b0, rst_n = 1'b1, ena = 1'b0;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0, fails = 0;
  int m_count, m_cmp, m_step;
  bit m_run, m_dir, m_match, m_wrap;

  tt_um_initial_project dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_count = 0; m_cmp = 128; m_step = 1;
    m_run = 0; m_dir = 0; m_match = 0; m_wrap = 0;
  endtask

  task automatic m_update(input bit en, input bit stb, input int op, input int d);
    if (!en) return;
    if (stb) begin
      case (op)
        1: m_count = d;
        2: m_cmp = d;
        3: m_step = d;
        4: begin m_run = 1; m_dir = 0; end
        5: begin m_run = 1; m_dir = 1; end
        6: m_run = 0;
        7: begin m_count = 0; m_match = 0; m_wrap = 0; end
        default: ;
      endcase
    end else if (m_run) begin
      if (!m_dir) begin
        if (m_count + m_step > 255) m_wrap = 1;
        m_count = (m_count + m_step) % 256;
      end else begin
        if (m_count < m_step) m_wrap = 1;
        m_count = (m_count - m_step + 256) % 256;
      end
      if (m_count == m_cmp) m_match = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] e_uio;
    e_uio = {m_wrap, m_match, m_run, m_count < m_cmp, 4'b0000};
    chk({tag, "_uo"}, uo_out, 8'(m_count));
    chk({tag, "_uio"}, uio_out, e_uio);
    chk({tag, "_oe"}, uio_oe, 8'hF0);
  endtask

  task automatic cyc(input string tag, input bit en, input bit stb, input int op, input int d);
    @(negedge clk);
    ena = en;
    uio_in = {4'($urandom), stb, 3'(op)};
    ui_in = 8'(d);
    @(posedge clk);
    m_update(en, stb, op, d);
    #1 chk_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1, 0, $urandom_range(0, 7), $urandom);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h10);
    chk("rst_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) idle("idle");
    chk("idle_hold_uo", uo_out, 8'h00);
    chk("idle_hold_uio", uio_out, 8'h10);

    cyc("load_fe", 1, 1, 1, 8'hFE);
    cyc("runup", 1, 1, 4, 0);
    idle("wrap1");
    chk("wrap1_val", uo_out, 8'hFF);
    chk("wrap1_f", {7'b0, uio_out[7]}, 8'h00);
    idle("wrap2");
    chk("wrap2_val", uo_out, 8'h00);
    chk("wrap2_f", {7'b0, uio_out[7]}, 8'h01);
    idle("wrap3");
    chk("wrap3_val", uo_out, 8'h01);
    chk("wrap3_f", {7'b0, uio_out[7]}, 8'h01);

    cyc("clr0", 1, 1, 7, 0);
    cyc("setstep5", 1, 1, 3, 5);
    cyc("setcmp", 1, 1, 2, 8'h0F);
    cyc("load0", 1, 1, 1, 0);
    cyc("runup2", 1, 1, 4, 0);
    idle("m5");
    chk("m5_val", uo_out, 8'd5);
    chk("m5_pm", {6'b0, uio_out[6], uio_out[4]}, 8'h01);
    idle("m10");
    chk("m10_val", uo_out, 8'd10);
    idle("m15");
    chk("m15_val", uo_out, 8'd15);
    chk("m15_pm", {6'b0, uio_out[6], uio_out[4]}, 8'h02);
    idle("m20");
    chk("m20_pm", {6'b0, uio_out[6], uio_out[4]}, 8'h02);

    cyc("load3", 1, 1, 1, 3);
    cyc("setstep2", 1, 1, 3, 2);
    cyc("rundn", 1, 1, 5, 0);
    idle("d1");
    chk("d1_val", uo_out, 8'h01);
    idle("dff");
    chk("dff_val", uo_out, 8'hFF);
    chk("dff_wrap", {7'b0, uio_out[7]}, 8'h01);
    cyc("clear", 1, 1, 7, 0);
    chk("clear_val", uo_out, 8'h00);
    chk("clear_uio", uio_out, 8'h30);

    for (int i = 0; i < 4; i++) cyc("ena0", 0, 0, 0, 0);
    chk("ena0_frozen", uo_out, 8'h00);
    cyc("ena0_load", 0, 1, 1, 8'h55);
    chk("ena0_load_val", uo_out, 8'h00);
    idle("resume");
    chk("resume_val", uo_out, 8'hFE);

    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    m_reset();
    chk("arst_uo", uo_out, 8'h00);
    chk("arst_uio", uio_out, 8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) idle("post_rst");
    chk("post_rst_idle", uo_out, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
        #1 m_reset();
        chk_all("rnd_rst");
        @(negedge clk);
        rst_n = 1'b0;
      end
      cyc("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7), $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 255));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
